// File: rtl/muldiv_alu_controller_if.sv
// EX-stage bundle between the pipeline and the ALU/MUL-DIV controller.
// master = pipeline side (drives the decoded instruction), slave = controller.
interface muldiv_alu_controller_if;
  logic       ValidEX;
  logic       RType;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic       Flush;
  logic [3:0] Operation;
  logic       MdStart;
  logic [2:0] MdOp;
  logic       MdKill;
  logic       MdValid;
  logic       Stall;

  modport master (
    output ValidEX, RType, ALUOp, Funct7, Funct3, Flush,
    input  Operation, MdStart, MdOp, MdKill, MdValid, Stall
  );

  modport slave (
    input  ValidEX, RType, ALUOp, Funct7, Funct3, Flush,
    output Operation, MdStart, MdOp, MdKill, MdValid, Stall
  );
endinterface

// File: rtl/muldiv_alu_controller.sv
// EX-stage ALU decode plus RV32M sequencing: launch/stall in the op's own cycle,
// MdValid N+1 cycles after launch (N = MUL/DIV latency); Stall holds IF/ID/EX meanwhile.
module muldiv_alu_controller #(
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  muldiv_alu_controller_if.slave bus
);
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_md_op;

  logic       w_m_op;
  logic       w_launch;
  logic [3:0] w_alu_op;

  always_comb begin
    w_alu_op = 4'b0100;
    case (bus.ALUOp)
      2'b00: w_alu_op = 4'b0100;
      2'b01: w_alu_op = 4'b1000;
      2'b11: w_alu_op = 4'b1101;
      default: begin
        case (bus.Funct3)
          3'b000: w_alu_op = (bus.RType && bus.Funct7 == 7'b0100000) ? 4'b0101 : 4'b0100;
          3'b001: w_alu_op = 4'b0110;
          3'b010: w_alu_op = 4'b1010;
          3'b011: w_alu_op = 4'b1011;
          3'b100: w_alu_op = 4'b0010;
          3'b101: w_alu_op = bus.Funct7[5] ? 4'b1001 : 4'b0111;
          3'b110: w_alu_op = 4'b0001;
          3'b111: w_alu_op = 4'b0000;
          default: w_alu_op = 4'b0100;
        endcase
      end
    endcase
  end

  // Launch, kill and stall must act in the same cycle the op is seen,
  // so they are decoded from the state and the live inputs.
  always_comb begin
    w_m_op   = ENABLE_M && bus.ValidEX && bus.RType && (bus.ALUOp == 2'b10)
               && (bus.Funct7 == 7'b0000001);
    w_launch = !reset && (r_state == S_IDLE) && w_m_op && !bus.Flush;

    bus.Operation = w_m_op ? 4'b1100 : w_alu_op;
    bus.MdStart   = w_launch;
    bus.MdOp      = r_md_op;
    bus.MdKill    = !reset && (r_state == S_BUSY) && bus.Flush;
    bus.MdValid   = !reset && (r_state == S_DONE);
    bus.Stall     = !reset && (((r_state == S_IDLE) && w_m_op && !bus.Flush)
                               || ((r_state == S_BUSY) && !bus.Flush));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_md_op <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_md_op <= bus.Funct3;
            r_cnt   <= bus.Funct3[2] ? DIV_LOAD : MUL_LOAD;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.Flush)          r_state <= S_IDLE;
          else if (r_cnt == '0)   r_state <= S_DONE;
          else                    r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_alu_controller.sv
// Three controllers (default, MUL_CYCLES=1, ENABLE_M=0) share one stimulus stream;
// each is compared every cycle with a timeline model of its expected behaviour.
module tb_muldiv_alu_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, valid_ex, rtype, flush;
  logic [1:0] alu_op;
  logic [6:0] f7;
  logic [2:0] f3;

  logic [3:0] o_op    [3];
  logic [2:0] o_mdop  [3];
  logic       o_start [3];
  logic       o_kill  [3];
  logic       o_valid [3];
  logic       o_stall [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    muldiv_alu_controller_if bus();
    assign bus.ValidEX = valid_ex;
    assign bus.RType   = rtype;
    assign bus.ALUOp   = alu_op;
    assign bus.Funct7  = f7;
    assign bus.Funct3  = f3;
    assign bus.Flush   = flush;
    assign o_op[g]     = bus.Operation;
    assign o_mdop[g]   = bus.MdOp;
    assign o_start[g]  = bus.MdStart;
    assign o_kill[g]   = bus.MdKill;
    assign o_valid[g]  = bus.MdValid;
    assign o_stall[g]  = bus.Stall;
    muldiv_alu_controller #(
      .ENABLE_M   (g != 2),
      .MUL_CYCLES (g == 1 ? 1 : 3),
      .DIV_CYCLES (32)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  int total = 0;
  int bad   = 0;

  // model: an in-flight op is remembered by its age (cycles since launch) and latency
  bit         pend   [3];
  int         age    [3];
  int         lat    [3];
  logic [2:0] m_mdop [3];

  int stall_cnt [3];
  int valid_cnt [3];
  int valid_cyc [3];
  int cyc;

  function automatic bit en_m(int i);
    return i != 2;
  endfunction

  function automatic int mul_lat(int i);
    return (i == 1) ? 1 : 3;
  endfunction

  function automatic logic [3:0] ref_op(logic [1:0] a, logic [2:0] fn3, logic [6:0] fn7, logic r);
    logic [3:0] tab [8];
    logic [3:0] res;
    tab = '{4'h4, 4'h6, 4'hA, 4'hB, 4'h2, 4'h7, 4'h1, 4'h0};
    if (a == 2'b00)      res = 4'h4;
    else if (a == 2'b01) res = 4'h8;
    else if (a == 2'b11) res = 4'hD;
    else if (fn3 == 3'd0 && r && fn7 == 7'b0100000) res = 4'h5;
    else if (fn3 == 3'd5 && fn7[5]) res = 4'h9;
    else res = tab[fn3];
    return res;
  endfunction

  task automatic check(string tag, int i, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d cyc%0d: got %0d expected %0d", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      stall_cnt[i] = 0; valid_cnt[i] = 0; valid_cyc[i] = -1;
    end
    cyc = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      bit         mop;
      logic [3:0] e_op;
      logic [2:0] e_mdop;
      bit         e_start, e_kill, e_valid, e_stall;
      mop = en_m(i) && valid_ex && rtype && alu_op == 2'b10 && f7 == 7'b0000001;
      e_op = mop ? 4'hC : ref_op(alu_op, f3, f7, rtype);
      e_mdop = m_mdop[i];
      e_start = 0; e_kill = 0; e_valid = 0; e_stall = 0;
      if (reset) begin
        pend[i] = 0; m_mdop[i] = 3'd0;
      end else if (pend[i] && age[i] <= lat[i]) begin
        if (flush) begin e_kill = 1; pend[i] = 0; end
        else begin e_stall = 1; age[i]++; end
      end else if (pend[i]) begin
        e_valid = 1; pend[i] = 0;
      end else if (mop && !flush) begin
        e_start = 1; e_stall = 1; pend[i] = 1; age[i] = 1;
        lat[i] = f3[2] ? 32 : mul_lat(i);
        m_mdop[i] = f3;
      end
      check("Operation", i, int'(o_op[i]),    int'(e_op));
      check("MdOp",      i, int'(o_mdop[i]),  int'(e_mdop));
      check("MdStart",   i, int'(o_start[i]), int'(e_start));
      check("MdKill",    i, int'(o_kill[i]),  int'(e_kill));
      check("MdValid",   i, int'(o_valid[i]), int'(e_valid));
      check("Stall",     i, int'(o_stall[i]), int'(e_stall));
      if (o_stall[i]) stall_cnt[i]++;
      if (o_valid[i]) begin
        valid_cnt[i]++;
        if (valid_cyc[i] < 0) valid_cyc[i] = cyc;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    valid_ex = 0; rtype = 0; alu_op = 2'b00; f7 = 7'd0; f3 = 3'd0; flush = 0;
  endtask

  task automatic set_m(logic [2:0] fn3);
    valid_ex = 1; rtype = 1; alu_op = 2'b10; f7 = 7'b0000001; f3 = fn3; flush = 0;
  endtask

  task automatic drain(int n);
    set_idle();
    repeat (n) step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      pend[i] = 0; age[i] = 0; lat[i] = 0; m_mdop[i] = 3'd0;
    end
    clr();
    // reset with an M op presented: all handshake outputs stay low
    reset = 1; set_m(3'b100);
    step(); step();
    reset = 0; drain(2);

    // decode sweep
    for (int a = 0; a < 4; a++)
      for (int fn = 0; fn < 8; fn++)
        for (int r = 0; r < 2; r++)
          for (int k = 0; k < 2; k++) begin
            valid_ex = 1; rtype = r[0]; alu_op = 2'(a); f3 = 3'(fn);
            f7 = k[0] ? 7'b0100000 : 7'b0000000; flush = 0;
            step();
          end
    drain(2);

    // MUL held for three cycles, then the pipeline moves on
    clr();
    set_m(3'b000);
    repeat (3) step();
    drain(6);
    check("mul_stall_cycles", 0, stall_cnt[0], 4);
    check("mul_valid_cycle",  0, valid_cyc[0], 4);
    check("mul_stall_cycles", 1, stall_cnt[1], 2);
    check("mul_valid_cycle",  1, valid_cyc[1], 2);
    check("nom_stall_cycles", 2, stall_cnt[2], 0);
    check("nom_valid_count",  2, valid_cnt[2], 0);

    // DIV immediately followed by MULHU
    clr();
    set_m(3'b100);
    repeat (34) step();
    check("div_stall_cycles", 0, stall_cnt[0], 33);
    check("div_valid_cycle",  0, valid_cyc[0], 33);
    set_m(3'b011);
    repeat (5) step();
    drain(40);

    // flush in BUSY cycle 5 of a DIV
    clr();
    set_m(3'b101);
    repeat (5) step();
    flush = 1;
    step();
    drain(40);
    check("flushed_div_valid", 0, valid_cnt[0], 0);

    // flush on the launch cycle
    clr();
    set_m(3'b000); flush = 1;
    step();
    drain(3);
    check("flush_launch_stall", 0, stall_cnt[0], 0);
    check("flush_launch_stall", 1, stall_cnt[1], 0);

    // flush while in DONE still delivers MdValid
    clr();
    set_m(3'b001);
    repeat (4) step();
    flush = 1;
    step();
    drain(6);
    check("flush_done_valid", 0, valid_cnt[0], 1);

    // reset mid-BUSY, then a fresh MUL
    set_m(3'b110);
    repeat (4) step();
    reset = 1;
    step();
    reset = 0;
    drain(1);
    clr();
    set_m(3'b010);
    repeat (6) step();
    drain(6);
    check("post_reset_mul_valid", 0, valid_cyc[0], 4);

    // randomized stream
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) begin
        valid_ex = ($urandom_range(0, 3) != 0);
        rtype    = 1'($urandom_range(0, 1));
        alu_op   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
        case ($urandom_range(0, 4))
          0:       f7 = 7'b0000000;
          1:       f7 = 7'b0100000;
          2, 3:    f7 = 7'b0000001;
          default: f7 = 7'($urandom);
        endcase
        f3 = 3'($urandom);
      end
      step();
    end
    reset = 0;
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
